// File: rtl/pipelined_addsub.sv
// Carry-chunked add/sub pipeline, STAGES ranks of WIDTH/STAGES bits.
// valid/ready stream in (x, y, sub) and out (sum, carry, overflow).
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int C = WIDTH / STAGES;
  localparam int T = STAGES - 1;
  localparam logic [WIDTH:0] ONE_C =
    (WIDTH+1)'(1) << C;
  localparam logic [WIDTH-1:0] MASK =
    WIDTH'(ONE_C - 1'b1);

  if (WIDTH < 2 || WIDTH % STAGES != 0)
  begin : g_bad_cfg
    $error("pipelined_addsub: bad WIDTH/STAGES");
  end

  logic             adv;

  // a_q holds computed sum chunks below the
  // stage boundary and raw x bits above it.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic             c_q [STAGES];
  logic             ov_q;

  logic             v_d [STAGES];
  logic [WIDTH-1:0] a_i [STAGES];
  logic [WIDTH-1:0] b_i [STAGES];
  logic             c_i [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic             c_d [STAGES];
  logic             ov_d;

  assign adv      = !v_q[T] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++)
  begin : g_stg
    localparam int LO = k * C;
    logic [C:0] part;

    if (k == 0) begin : g_head
      assign a_i[k] = x;
      assign b_i[k] = sub ? ~y : y;
      assign c_i[k] = sub;
      assign v_d[k] = in_valid;
    end else begin : g_body
      assign a_i[k] = a_q[k-1];
      assign b_i[k] = b_q[k-1];
      assign c_i[k] = c_q[k-1];
      assign v_d[k] = v_q[k-1];
    end

    assign part =
      {1'b0, a_i[k][LO +: C]} +
      {1'b0, b_i[k][LO +: C]} +
      {{C{1'b0}}, c_i[k]};

    // Splice this chunk's sum over the x bits.
    assign a_d[k] =
      (a_i[k] & ~(MASK << LO)) |
      (WIDTH'(part[C-1:0]) << LO);
    assign c_d[k] = part[C];
  end

  // Last stage still sees x MSB in a_i before
  // it is replaced by the sum MSB.
  assign ov_d =
    (a_i[T][WIDTH-1] == b_i[T][WIDTH-1]) &&
    (a_d[T][WIDTH-1] != a_i[T][WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ov_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_i[k];
        c_q[k] <= c_d[k];
      end
      ov_q <= ov_d;
    end
  end

  assign out_valid = v_q[T];
  assign sum       = a_q[T];
  assign carry     = c_q[T];
  assign overflow  = ov_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub.
// Random and directed beats vs arithmetic model.
module tb_pipelined_addsub;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x(x),
    .y(y),
    .sub(sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .carry(carry),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           ed;
    bit           lat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               nm, got, exp);
    end
  endtask

  // Plain integer arithmetic reference.
  function automatic exp_t model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic s);
    exp_t e;
    int sa;
    int sb;
    int r;
    sa = $signed(a);
    sb = $signed(b);
    if (s) begin
      r   = sa - sb;
      e.c = (a >= b);
      e.s = a - b;
    end else begin
      r   = sa + sb;
      e.c = (int'(a) + int'(b)) > 65535;
      e.s = a + b;
    end
    e.o   = (r > 32767) || (r < -32768);
    e.ed  = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic beat(input bit iv,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic s,
                      input bit ordy,
                      input bit lat,
                      output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    x         = a;
    y         = b;
    sub       = s;
    out_ready = ordy;
    #1;
    acc = rst_n && iv && in_ready;
    if (acc) begin
      e     = model(a, b, s);
      e.ed  = cyc + 1;
      e.lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++)
      beat(0, '0, '0, 0, 1, 0, acc);
  endtask

  task automatic drain();
    bit acc;
    int t;
    t = 0;
    while (q.size() > 0 && t < 60) begin
      beat(0, '0, '0, 0, 1, 0, acc);
      t++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: pops on every output transfer.
  initial begin : monitor
    exp_t e;
    logic [W-1:0] hs;
    logic hc;
    logic ho;
    bit stall;
    stall = 0;
    hs = '0;
    hc = 0;
    ho = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall = 0;
      end else begin
        chk("in_ready", in_ready,
            !(out_valid && !out_ready));
        if (stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_sum", sum, hs);
          chk("hold_carry", carry, hc);
          chk("hold_ovf", overflow, ho);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("spurious_valid", out_valid, 0);
          end else begin
            e = q.pop_front();
            chk("sum", sum, e.s);
            chk("carry", carry, e.c);
            chk("overflow", overflow, e.o);
            if (e.lat)
              chk("latency", cyc, e.ed + 3);
          end
        end
        stall = out_valid && !out_ready;
        hs = sum;
        hc = carry;
        ho = overflow;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  logic [W-1:0] dx [6];
  logic [W-1:0] dy [6];
  logic         ds [6];

  initial begin : main
    bit acc;
    int i;
    int t;
    dx = '{16'h00FF, 16'hFFFF, 16'h7FFF,
           16'h7FFF, 16'h0003, 16'h0005};
    dy = '{16'h0001, 16'h0001, 16'h0001,
           16'hFFFF, 16'h0005, 16'h0003};
    ds = '{1'b0, 1'b0, 1'b0,
           1'b1, 1'b1, 1'b1};

    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++)
      beat(1, dx[k], dy[k], ds[k], 1, 1, acc);
    idle(6);

    for (int k = 0; k < 12; k++)
      beat(k % 2 == 0, W'($urandom),
           W'($urandom), 1'($urandom),
           1, 1, acc);
    idle(6);

    i = 0;
    t = 0;
    while (i < 10 && t < 40) begin
      beat(1, W'($urandom), W'($urandom),
           1'(i % 2), !(t >= 4 && t <= 6),
           0, acc);
      if (acc) i++;
      t++;
    end
    chk("bp_beats", i, 10);
    drain();

    repeat (300)
      beat($urandom_range(0, 3) != 0,
           W'($urandom), W'($urandom),
           1'($urandom),
           $urandom_range(0, 9) < 7, 0, acc);
    drain();

    beat(1, 16'h1234, 16'h1111, 0, 1, 1, acc);
    beat(1, 16'h5000, 16'h0123, 1, 1, 1, acc);
    beat(1, 16'h00FF, 16'h0001, 0, 1, 1, acc);
    beat(0, '0, '0, 0, 0, 0, acc);
    @(negedge clk);
    #3;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_carry", carry, 0);
    chk("mid_rst_ovf", overflow, 0);
    beat(1, 16'h0101, 16'h0202, 0, 1, 0, acc);
    beat(1, 16'h0303, 16'h0404, 1, 1, 0, acc);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    idle(8);
    beat(1, 16'hFFFF, 16'h0001, 0, 1, 1, acc);
    drain();
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the team's fixed 8-bit gate-level ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands through a STAGES-deep carry-chunked pipeline.
- Each stage resolves WIDTH/STAGES bits and registers the carry into the next stage.
- Uses a valid/ready handshake with backpressure, so it sits directly in datapath streams that can stall.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages.
  - WIDTH % STAGES must be 0; violation is an elaboration-time error.
  - CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- sub  input  1  0 = x+y; 1 = x−y.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts a result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry  output  1  carry-out of the MSB.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits clear, out_valid=0, sum=0, carry=0, overflow=0.
  - in_ready may be 1 during reset; beats offered while rst_n is low are dropped.
  - Release is synchronous to clk by the upstream reset synchroniser.
- Advance and acceptance:
  - advance = !out_valid || out_ready (single global enable).
  - in_ready = advance, combinational, with no dependence on in_valid.
  - Accept = in_valid && in_ready.
  - When advance=0, every pipeline register holds (valid, data, carry).
  - When advance=1, every stage shifts one slot.
  - A non-accepted cycle with advance=1 inserts a bubble (valid=0).
- Arithmetic:
  - Effective operand yb = sub ? ~y : y; carry-in c0 = sub.
  - Stage k (0..STAGES−1) computes bits [k*CHUNK +: CHUNK] of x + yb, using c0 for k=0 or the registered carry from stage k−1.
  - Not-yet-processed upper chunks of x/yb travel with the beat (skew registers).
  - Already-computed lower sum chunks travel with the beat (deskew registers).
- Outputs of the final stage:
  - sum = full WIDTH result.
  - carry = carry-out of bit WIDTH−1. For sub: carry=1 means no borrow (x ≥ y unsigned); carry=0 means borrow.
  - overflow = (xMSB == ybMSB) && (sumMSB != xMSB), using yb.
- Latency:
  - A beat accepted at edge N appears with out_valid=1 after edge N+STAGES−1, i.e. in the cycle following edge N+STAGES−1.
  - STAGES=1 is a single registered ripple adder with latency 1.
  - Stall cycles add one cycle each.
- Throughput: one beat per cycle while out_ready=1. Order is preserved; no beat is lost or duplicated.
- Output stability: while out_valid=1 and out_ready=0, sum/carry/overflow stay constant.
- Bubbles: sum/carry/overflow contents are don't-care while out_valid=0, except after reset (0).
- Per-beat mode: sub is sampled per beat with the operands, so add and sub beats may alternate back-to-back.
- Reset mid-flight: every in-flight beat is discarded immediately, and none reappears after release.

Test Plan:
All scenarios use WIDTH=16, STAGES=4 with out_ready=1 unless stated.
- Add, 0x00FF+0x0001: accept at edge 0 → out_valid high after edge 3; sum=0x0100, carry=0, overflow=0.
- Add, 0xFFFF+0x0001 (carry ripples through all 4 stages) → sum=0x0000, carry=1, overflow=0. Add, 0x7FFF+0x0001 → sum=0x8000, carry=0, overflow=1.
- Sub, 0x7FFF−0xFFFF → sum=0x8000, carry=0, overflow=1. Sub, 0x0003−0x0005 → sum=0xFFFE, carry=0 (borrow), overflow=0. Sub, 0x0005−0x0003 → 0x0002, carry=1.
- Backpressure:
  - Stimulus: 10 back-to-back beats alternating add/sub; out_ready low for 3 cycles mid-stream.
  - Required: in_ready low exactly while out_valid=1 and out_ready=0; outputs held during the stall; 10 results in order matching the golden model; zero errors.
- Bubbles: in_valid pattern 1,0,1,0,… → out_valid shows the same pattern delayed 4 cycles.
- Async reset mid-flight:
  - Stimulus: rst_n low between edges while 3 beats are in flight.
  - Required: out_valid, sum, carry, overflow go to 0 without a clock edge; no stale beat appears after release; a new beat returns the correct result with 4-cycle latency.
